sync_packet_framer: RTL and testbench

SYNC_PACKET_FRAMER -- requirements
Module: sync_packet_framer

---
 rtl/sync_packet_framer.sv | 152 +++++++++++++++
 tb/tb_sync_packet_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_packet_framer.sv
// rtl/sync_packet_framer.sv - serial sync-word hunter and payload framer
// Define FRAMER_STATS_EN to build the pkt_count/abort_count statistics counters.
module sync_packet_framer #(
    parameter int                SYNC_W       = 32,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 32'hA5A5A5A5,
    parameter int                LEN_W        = 16,
    parameter int                MAX_ERR      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data,
    input  logic              data_valid,
    input  logic [SYNC_W-1:0] sync_mask,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic              abort,
    output logic              newpacket,
    output logic              payload_bit,
    output logic              payload_valid,
    output logic              sop,
    output logic              eop,
    output logic [15:0]       pkt_count,
    output logic [15:0]       abort_count
);

    localparam int FILL_W = $clog2(SYNC_W + 1);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t state_q, state_d;

    // Only the SYNC_W-1 oldest bits are stored; the incoming bit completes the window.
    logic [SYNC_W-2:0] sh_q;
    logic [FILL_W-1:0] fill_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;

    logic [SYNC_W-1:0] cand;
    logic [SYNC_W-1:0] diff;
    logic [FILL_W-1:0] err_cnt;
    logic              fill_full;
    logic              match;
    logic              last_bit;

    assign cand      = {sh_q, data};
    assign diff      = (cand ^ SYNC_PATTERN) & sync_mask;
    // Requiring SYNC_W fresh bits stops a match borrowing bits from before a packet or abort.
    assign fill_full = (fill_q == FILL_W'(SYNC_W - 1));
    // A captured length of 0 wraps to all ones, giving 2^LEN_W payload bits.
    assign last_bit  = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            err_cnt = err_cnt + FILL_W'(diff[i]);
        end
    end

    assign match = data_valid && !abort && (|sync_mask) && fill_full
                   && (int'(err_cnt) <= MAX_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (match) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (abort) begin
                    state_d = HUNT;
                end else if (data_valid && last_bit) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign newpacket = (state_q == PAYLOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q          <= '0;
            fill_q        <= '0;
            cnt_q         <= '0;
            len_q         <= '0;
            payload_bit   <= 1'b0;
            payload_valid <= 1'b0;
            sop           <= 1'b0;
            eop           <= 1'b0;
        end else begin
            payload_valid <= 1'b0;
            sop           <= 1'b0;
            eop           <= 1'b0;
            if (state_q == HUNT) begin
                if (abort || match) begin
                    sh_q   <= '0;
                    fill_q <= '0;
                    if (match) begin
                        cnt_q <= '0;
                        len_q <= payload_len;
                    end
                end else if (data_valid) begin
                    sh_q <= cand[SYNC_W-2:0];
                    if (!fill_full) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
            end else begin
                sh_q   <= '0;
                fill_q <= '0;
                if (abort) begin
                    cnt_q <= '0;
                end else if (data_valid) begin
                    payload_bit   <= data;
                    payload_valid <= 1'b1;
                    sop           <= (cnt_q == '0);
                    eop           <= last_bit;
                    cnt_q         <= last_bit ? '0 : cnt_q + LEN_W'(1);
                end
            end
        end
    end

`ifdef FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count   <= '0;
            abort_count <= '0;
        end else if (state_q == PAYLOAD) begin
            if (abort) begin
                abort_count <= abort_count + 16'd1;
            end else if (data_valid && last_bit) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
`else
    assign pkt_count   = '0;
    assign abort_count = '0;
`endif

endmodule

// File: tb/tb_sync_packet_framer.sv
// tb/tb_sync_packet_framer.sv - scoreboard bench for sync_packet_framer
module tb_sync_packet_framer;

`ifdef FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, data, data_valid, abort;
    logic [31:0] sync_mask;
    logic [15:0] payload_len;

    logic        newpacket, payload_bit, payload_valid, sop, eop;
    logic [15:0] pkt_count, abort_count;
    logic        newpacket2, payload_bit2, payload_valid2, sop2, eop2;
    logic [15:0] pkt_count2, abort_count2;

    always #5 clk = ~clk;

    sync_packet_framer u_dut (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
        .sync_mask(sync_mask), .payload_len(payload_len), .abort(abort),
        .newpacket(newpacket), .payload_bit(payload_bit), .payload_valid(payload_valid),
        .sop(sop), .eop(eop), .pkt_count(pkt_count), .abort_count(abort_count)
    );

    sync_packet_framer #(.MAX_ERR(2)) u_dut_tol (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
        .sync_mask(sync_mask), .payload_len(payload_len), .abort(abort),
        .newpacket(newpacket2), .payload_bit(payload_bit2), .payload_valid(payload_valid2),
        .sop(sop2), .eop(eop2), .pkt_count(pkt_count2), .abort_count(abort_count2)
    );

    typedef struct {
        logic bit_v;
        logic sop;
        logic eop;
        time  due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input logic v, input logic push, input logic s, input logic e);
        data       = b;
        data_valid = v;
        @(posedge clk);
        if (push) q.push_back('{bit_v: b, sop: s, eop: e, due: $time});
        #1;
        data       = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) drive(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_payload(input logic [63:0] p, input int n, input bit gapped);
        for (int i = n - 1; i >= 0; i--) begin
            drive(p[i], 1'b1, 1'b1, i == n - 1, i == 0);
            if (gapped) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_newpacket"}, 32'(newpacket), 0);
        check({tag, "_payload_valid"}, 32'(payload_valid), 0);
        check({tag, "_sop"}, 32'(sop), 0);
        check({tag, "_eop"}, 32'(eop), 0);
        check({tag, "_pkt_count"}, 32'(pkt_count), 0);
        check({tag, "_abort_count"}, 32'(abort_count), 0);
    endtask

    // Output monitor: every payload_valid must match the oldest expected bit, one cycle after input.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (payload_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got payload_valid=1 expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("payload_bit", 32'(payload_bit), 32'(e.bit_v));
                    check("sop", 32'(sop), 32'(e.sop));
                    check("eop", 32'(eop), 32'(e.eop));
                    check("latency", 32'($time - e.due), 32'd5);
                end
            end else if (q.size() > 0 && $time > q[0].due + 5) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: got none expected bit %0b at %0t", q[0].bit_v, $time);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        data        = 1'b0;
        data_valid  = 1'b0;
        abort       = 1'b0;
        sync_mask   = 32'hFFFF_FFFF;
        payload_len = 16'd8;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic packet: sync then 8'h3C.
        send_bits(32'hA5A5A5A5, 31, 1);
        check("np_before_last_sync", 32'(newpacket), 0);
        send_bits(32'hA5A5A5A5, 0, 0);
        check("np_after_sync", 32'(newpacket), 1);
        send_payload(64'h3C, 8, 1'b0);
        check("np_after_eop", 32'(newpacket), 0);
        idle(2);
        check("pkt_count_1", 32'(pkt_count), STATS ? 1 : 0);

        // Masked low nibble, length 1 packet.
        sync_mask   = 32'hFFFF_FFF0;
        payload_len = 16'd1;
        send_bits(32'hA5A5A5AF, 31, 0);
        check("mask_match", 32'(newpacket), 1);
        send_payload(64'h1, 1, 1'b0);
        check("len1_np", 32'(newpacket), 0);
        sync_mask = 32'hFFFF_FFFF;
        idle(2);
        check("pkt_count_2", 32'(pkt_count), STATS ? 2 : 0);

        // Error tolerance: one bit off vs three bits off.
        send_bits(32'hA5A5A5A4, 31, 0);
        check("err1_exact_dut", 32'(newpacket), 0);
        check("err1_tol_dut", 32'(newpacket2), 1);
        pulse_abort();
        check("tol_aborted", 32'(newpacket2), 0);
        send_bits(32'hA5A5A5A2, 31, 0);
        check("err3_tol_dut", 32'(newpacket2), 0);
        check("err3_exact_dut", 32'(newpacket), 0);
        pulse_abort();
        check("hunt_abort_count", 32'(abort_count), 0);

        // Gapped data_valid, length 5.
        payload_len = 16'd5;
        send_bits(32'hA5A5A5A5, 31, 0);
        check("gap_np", 32'(newpacket), 1);
        send_payload(64'b10110, 5, 1'b1);
        check("gap_np_after", 32'(newpacket), 0);
        idle(2);
        check("pkt_count_3", 32'(pkt_count), STATS ? 3 : 0);

        // Abort after 3 bits of a 16 bit packet, then resync from scratch.
        payload_len = 16'd16;
        send_bits(32'hA5A5A5A5, 31, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_abort();
        check("abort_np", 32'(newpacket), 0);
        idle(2);
        check("abort_count_1", 32'(abort_count), STATS ? 1 : 0);
        check("pkt_count_after_abort", 32'(pkt_count), STATS ? 3 : 0);
        payload_len = 16'd2;
        send_bits(32'hA5A5A5A5, 31, 1);
        check("resync_partial", 32'(newpacket), 0);
        send_bits(32'hA5A5A5A5, 0, 0);
        check("resync_np", 32'(newpacket), 1);
        send_payload(64'b01, 2, 1'b0);
        idle(2);
        check("pkt_count_4", 32'(pkt_count), STATS ? 4 : 0);

        // Reset in the middle of a payload.
        payload_len = 16'd8;
        send_bits(32'hA5A5A5A5, 31, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all_zero("midreset");
        rst_n = 1'b1;

        // Sync pattern inside a 64 bit payload must not retrigger or overlap.
        payload_len = 16'd64;
        send_bits(32'hA5A5A5A5, 31, 0);
        send_payload({32'hA5A5A5A5, 4'h0, 28'hA5A5A5A}, 64, 1'b0);
        check("len64_np", 32'(newpacket), 0);
        send_bits(32'h5, 3, 0);
        check("no_overlap", 32'(newpacket), 0);
        idle(2);
        check("pkt_count_len64", 32'(pkt_count), STATS ? 1 : 0);
        check("abort_count_len64", 32'(abort_count), 0);

        idle(3);
        check("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
